seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier.sv | 88 ++++++++
 tb/tb_seq_multiplier.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle shift-and-add MULT/MULTU producing the HI/LO product pair
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [WIDTH:0]     sum;
  logic               neg_q, neg_d, done_q, done_d;
  always_comb begin
    abs_a = (is_signed & a[WIDTH-1]) ? -a : a;
    abs_b = (is_signed & b[WIDTH-1]) ? -b : b;
    // The extra sum bit keeps the adder carry so unsigned products never overflow
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? mcand_q : {WIDTH{1'b0}}};
    prod = neg_q ? (~acc_q + ONE) : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    mcand_d = mcand_q;
    acc_d = acc_q;
    neg_d = neg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d = '0;
        mcand_d = abs_a;
        acc_d = {{WIDTH{1'b0}}, abs_b};
        neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        state_d = (cnt_q == LAST) ? FIX : RUN;
      end
      FIX: begin
        {hi_d, lo_d} = prod;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mcand_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcand_q <= mcand_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed-vector bench for seq_multiplier with immediate-assertion checks
module tb_seq_multiplier;
  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Drive start for exactly one edge (E0), then scramble operands to prove they were latched
  task automatic launch(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x;
    b = y;
    is_signed = s;
    start = 1'b1;
    step();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    is_signed = ~s;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask
  // n0 = edges already elapsed since E0 when called
  task automatic wait_done(input string tag, input int n0, input logic [31:0] eh, input logic [31:0] el);
    int n = n0;
    int bz = 0;
    bit held = 1'b1;
    logic [31:0] h0 = hi;
    logic [31:0] l0 = lo;
    while (n < 40) begin
      step();
      n++;
      if (done) break;
      if (busy) bz++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bz), 64'(32 - n0));
    chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_hold"}, {63'd0, held}, 64'd1);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
  endtask
  task automatic pulse_end(input string tag);
    step();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask
  initial begin
    int dn;
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    launch(32'd3, 32'd5, 1'b0);
    wait_done("u3x5", 0, 32'h0, 32'hF);
    pulse_end("u3x5");
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done("umax", 0, 32'hFFFFFFFE, 32'h1);
    pulse_end("umax");
    launch(32'hFFFFFFFD, 32'h7, 1'b1);
    wait_done("sm3x7", 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    pulse_end("sm3x7");
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done("sm1xm1", 0, 32'h0, 32'h1);
    pulse_end("sm1xm1");
    launch(32'h80000000, 32'h80000000, 1'b1);
    wait_done("smin", 0, 32'h40000000, 32'h0);
    pulse_end("smin");
    launch(32'h80000000, 32'h80000000, 1'b0);
    wait_done("umin", 0, 32'h40000000, 32'h0);
    pulse_end("umin");
    // A start pulse while busy must be ignored and must not queue
    launch(32'd6, 32'd7, 1'b0);
    repeat (4) step();
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("stray", 5, 32'h0, 32'd42);
    dn = 0;
    repeat (40) begin
      step();
      if (done) dn++;
    end
    chk("stray_no_second_done", 64'(dn), 64'd0);
    launch(32'd6, 32'd7, 1'b0);
    wait_done("b2b_first", 0, 32'h0, 32'd42);
    launch(32'd9, 32'd9, 1'b0);
    wait_done("b2b_second", 0, 32'h0, 32'd81);
    pulse_end("b2b_second");
    // Reset mid-RUN aborts the operation and clears the previous result
    launch(32'd100, 32'd100, 1'b0);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    dn = 0;
    repeat (40) begin
      step();
      if (done || busy) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    launch(32'd100, 32'd100, 1'b0);
    wait_done("after_abort", 0, 32'h0, 32'd10000);
    pulse_end("after_abort");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
